coef_sequencer: RTL and testbench

- Holds a bank of NUM_COEF signed 32-bit coefficients, written through a simple config port.
- On each start pulse, streams the coefficients in index order to a downstream MAC/filter datapath using a valid/ready handshake.
- Replaces hard-wired per-tap constant instances with one run-time-configurable source.
- Sits between the control/config logic and the filter MAC.

---
 rtl/coef_sequencer_if.sv | 35 +++
 rtl/coef_sequencer.sv | 114 +++++++++++
 tb/tb_coef_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/coef_sequencer_if.sv
// Config port and coefficient stream bundle for coef_sequencer.
// slave = sequencer side, master = controller/datapath side.
interface coef_sequencer_if #(
  parameter int ADDR_W = 3,
  parameter int WIDTH  = 32
);
  logic                     cfg_we;
  logic [ADDR_W-1:0]        cfg_addr;
  logic signed [WIDTH-1:0]  cfg_data;
  logic                     cfg_err;
  logic                     start;
  logic                     busy;
  logic signed [WIDTH-1:0]  coef_out;
  logic [ADDR_W-1:0]        coef_idx;
  logic                     coef_valid;
  logic                     coef_ready;
  logic                     coef_last;
  logic                     done;

  modport slave (
    input  cfg_we, cfg_addr, cfg_data,
    input  start, coef_ready,
    output cfg_err, busy, coef_out,
    output coef_idx, coef_valid,
    output coef_last, done
  );

  modport master (
    output cfg_we, cfg_addr, cfg_data,
    output start, coef_ready,
    input  cfg_err, busy, coef_out,
    input  coef_idx, coef_valid,
    input  coef_last, done
  );
endinterface

// File: rtl/coef_sequencer.sv
// Run-time coefficient bank streamed in index order per start pulse.
// Bank is write-locked during a pass so a pass sees one coefficient set.
module coef_sequencer #(
  parameter int NUM_COEF = 8,
  parameter int ADDR_W   = 3,
  parameter int WIDTH    = 32
) (
  input logic clk,
  input logic reset_n,
  coef_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(NUM_COEF - 1);
  localparam logic [ADDR_W:0] NUM =
    (ADDR_W + 1)'(NUM_COEF);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  bank_q [NUM_COEF];
  logic [WIDTH-1:0]  bank_d [NUM_COEF];

  logic xfer;
  logic addr_ok;
  logic wr_ok;

  always_comb begin
    xfer    = valid_q & bus.coef_ready;
    addr_ok = {1'b0, bus.cfg_addr} < NUM;
    wr_ok   = bus.cfg_we & addr_ok
            & (state_q != RUN);
    err_d   = bus.cfg_we & ~wr_ok;

    bank_d = bank_q;
    if (wr_ok) begin
      bank_d[bus.cfg_addr] = bus.cfg_data;
    end

    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          idx_d   = '0;
          valid_d = 1'b1;
        end
      end
      RUN: begin
        if (xfer) begin
          if (idx_q == LAST) begin
            state_d = DONE;
            idx_d   = '0;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_COEF; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
      bank_q  <= bank_d;
    end
  end

  // Combinational read of the registered index.
  assign bus.coef_out   = bank_q[idx_q];
  assign bus.coef_idx   = idx_q;
  assign bus.coef_valid = valid_q;
  assign bus.coef_last  = valid_q
                        & (idx_q == LAST);
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.cfg_err    = err_q;

endmodule

// File: tb/tb_coef_sequencer.sv
// Self-checking bench for coef_sequencer.
// Reference bank model plus expected stream rules.
module tb_coef_sequencer;
  localparam int N = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  coef_sequencer_if #(.ADDR_W(3), .WIDTH(32)) b ();
  coef_sequencer_if #(.ADDR_W(3), .WIDTH(32)) b6 ();

  coef_sequencer #(
    .NUM_COEF(8), .ADDR_W(3), .WIDTH(32)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(b)
  );

  coef_sequencer #(
    .NUM_COEF(6), .ADDR_W(3), .WIDTH(32)
  ) dut6 (
    .clk(clk), .reset_n(reset_n), .bus(b6)
  );

  int passed = 0;
  int total  = 0;
  logic [31:0] m [N];
  int vc;

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s: got %0h expected %0h",
                tag, o, e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a,
                    input logic [31:0] d);
    b.cfg_we   = 1'b1;
    b.cfg_addr = a;
    b.cfg_data = d;
    step();
    b.cfg_we = 1'b0;
    chk("wr_err", {31'd0, b.cfg_err}, 32'd0);
    m[a] = d;
  endtask

  // mode 0: full rate, 1: random ready, 2: 4-cycle stall at idx 3
  task automatic do_pass(input int mode,
                         input bit inject,
                         output int vcyc);
    int k = 0;
    int cyc = 0;
    int stall = 0;
    int inj_cyc = 2;
    bit rdy;
    logic [2:0] a;
    logic [31:0] d;
    b.start = 1'b1;
    if (inject) begin
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      b.cfg_we   = 1'b1;
      b.cfg_addr = a;
      b.cfg_data = d;
      m[a] = d;
    end
    step();
    b.start  = 1'b0;
    b.cfg_we = 1'b0;
    vcyc = 0;
    while (k < N && cyc < 100) begin
      chk("valid", {31'd0, b.coef_valid}, 32'd1);
      chk("idx", {29'd0, b.coef_idx}, 32'(k));
      chk("out", b.coef_out, m[k]);
      chk("last", {31'd0, b.coef_last},
          32'(k == N - 1));
      chk("busy", {31'd0, b.busy}, 32'd1);
      chk("done_run", {31'd0, b.done}, 32'd0);
      chk("run_err", {31'd0, b.cfg_err},
          32'(inject && cyc == inj_cyc + 1));
      case (mode)
        0: rdy = 1'b1;
        1: rdy = 1'($urandom_range(0, 1));
        default: begin
          rdy = !(k == 3 && stall < 4);
          if (!rdy) stall++;
        end
      endcase
      b.coef_ready = rdy;
      b.cfg_we   = inject && cyc == inj_cyc;
      b.cfg_addr = 3'd2;
      b.cfg_data = 32'h7FFF_FFFF;
      b.start    = inject && k == 5;
      vcyc++;
      step();
      if (rdy) k++;
      cyc++;
    end
    b.cfg_we = 1'b0;
    b.start  = 1'b0;
    if (k < N) chk("pass_timeout", 32'(k), 32'(N));
    chk("done_pulse", {31'd0, b.done}, 32'd1);
    chk("done_valid", {31'd0, b.coef_valid}, 32'd0);
    chk("done_busy", {31'd0, b.busy}, 32'd1);
    chk("done_idx", {29'd0, b.coef_idx}, 32'd0);
    chk("done_last", {31'd0, b.coef_last}, 32'd0);
    if (inject) begin
      // start ignored in DONE; a write is accepted there
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      b.start    = 1'b1;
      b.cfg_we   = 1'b1;
      b.cfg_addr = a;
      b.cfg_data = d;
      m[a] = d;
    end
    step();
    b.start  = 1'b0;
    b.cfg_we = 1'b0;
    chk("idle_done", {31'd0, b.done}, 32'd0);
    chk("idle_busy", {31'd0, b.busy}, 32'd0);
    chk("idle_valid", {31'd0, b.coef_valid}, 32'd0);
    chk("idle_err", {31'd0, b.cfg_err}, 32'd0);
  endtask

  initial begin
    logic [31:0] e;
    reset_n = 1'b0;
    b.cfg_we = 1'b0; b.cfg_addr = '0; b.cfg_data = '0;
    b.start = 1'b0;  b.coef_ready = 1'b0;
    b6.cfg_we = 1'b0; b6.cfg_addr = '0; b6.cfg_data = '0;
    b6.start = 1'b0;  b6.coef_ready = 1'b0;
    for (int i = 0; i < N; i++) m[i] = '0;
    repeat (3) step();

    chk("rst_valid", {31'd0, b.coef_valid}, 32'd0);
    chk("rst_idx", {29'd0, b.coef_idx}, 32'd0);
    chk("rst_out", b.coef_out, 32'd0);
    chk("rst_busy", {31'd0, b.busy}, 32'd0);
    chk("rst_done", {31'd0, b.done}, 32'd0);
    chk("rst_err", {31'd0, b.cfg_err}, 32'd0);
    reset_n = 1'b1;
    step();

    do_pass(0, 1'b0, vc);
    chk("zero_cycles", 32'(vc), 32'd8);

    for (int i = 0; i < N; i++) wr(3'(i), 32'(i * 1000 - 3500));
    do_pass(0, 1'b0, vc);
    chk("cfg_cycles", 32'(vc), 32'd8);

    do_pass(2, 1'b0, vc);
    chk("bp_cycles", 32'(vc), 32'd12);

    do_pass(0, 1'b1, vc);
    do_pass(0, 1'b0, vc);

    repeat (6) begin
      repeat (3) wr(3'($urandom_range(0, 7)), $urandom);
      do_pass(1, 1'($urandom_range(0, 1)), vc);
    end

    // asynchronous reset between edges at idx 4
    b.start = 1'b1;
    step();
    b.start = 1'b0;
    b.coef_ready = 1'b1;
    repeat (4) step();
    chk("pre_rst_idx", {29'd0, b.coef_idx}, 32'd4);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, b.coef_valid}, 32'd0);
    chk("arst_busy", {31'd0, b.busy}, 32'd0);
    chk("arst_idx", {29'd0, b.coef_idx}, 32'd0);
    chk("arst_out", b.coef_out, 32'd0);
    repeat (2) begin
      step();
      chk("arst_done", {31'd0, b.done}, 32'd0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) m[i] = '0;
    step();
    chk("arst_done2", {31'd0, b.done}, 32'd0);
    do_pass(0, 1'b0, vc);

    // six-entry instance: out-of-range writes rejected
    b6.cfg_we = 1'b1; b6.cfg_addr = 3'd7; b6.cfg_data = 32'd5;
    step();
    b6.cfg_we = 1'b0;
    chk("n6_err7", {31'd0, b6.cfg_err}, 32'd1);
    step();
    chk("n6_err_clr", {31'd0, b6.cfg_err}, 32'd0);
    b6.cfg_we = 1'b1; b6.cfg_addr = 3'd6; b6.cfg_data = 32'd6;
    step();
    chk("n6_err6", {31'd0, b6.cfg_err}, 32'd1);
    b6.cfg_addr = 3'd5; b6.cfg_data = 32'hDEAD_BEEF;
    step();
    chk("n6_ok5", {31'd0, b6.cfg_err}, 32'd0);
    b6.cfg_addr = 3'd0; b6.cfg_data = 32'h8000_0001;
    step();
    b6.cfg_we = 1'b0;
    b6.start = 1'b1;
    b6.coef_ready = 1'b1;
    step();
    b6.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      e = (i == 5) ? 32'hDEAD_BEEF :
          (i == 0) ? 32'h8000_0001 : 32'd0;
      chk("n6_valid", {31'd0, b6.coef_valid}, 32'd1);
      chk("n6_idx", {29'd0, b6.coef_idx}, 32'(i));
      chk("n6_out", b6.coef_out, e);
      chk("n6_last", {31'd0, b6.coef_last}, 32'(i == 5));
      step();
    end
    chk("n6_done", {31'd0, b6.done}, 32'd1);
    chk("n6_valid0", {31'd0, b6.coef_valid}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
